pll_lock_sequencer: RTL

//  Supervises the on-chip PLL that multiplies the 3.579 MHz cartridge clock (x42 CLKOUT, /2 CLKOUTD).

---
 rtl/pll_lock_sequencer_pkg.sv | 19 +
 rtl/pll_lock_sequencer_sync_2ff.sv | 30 +++
 rtl/pll_lock_sequencer.sv | 115 +++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding for the PLL lock sequencer and its status readout.
// Also provides the elaboration-time helper used to size the shared timer.
package pll_lock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-stage synchroniser for one asynchronous level, reset to 0.
// Latency 2 clk edges; no flow control.
module pll_lock_sequencer_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL supervisor: pulses PLL reset, retries on lock timeout, releases system reset after stable lock.
// Lock loss to sys_reset_n low is 3 clk edges; no flow control (soft_req is a 1-cycle pulse).
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_lock,
  input  logic             soft_req,
  output logic             pll_reset,
  output logic             sys_reset_n,
  output logic             locked,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] lost_count
);
  import pll_lock_sequencer_pkg::*;

  localparam int unsigned TMR_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  logic             lock_s;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] lost_q, lost_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic             locked_q, locked_d;

  pll_lock_sequencer_sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      ST_PLL_RST: begin
        if (timer_q == TMR_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_PLL_RST;
          if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          if (lost_q != '1) lost_d = lost_q + CNT_W'(1);
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    // A software restart overrides everything, including any counter bump above.
    if (soft_req) begin
      state_d = ST_PLL_RST;
      retry_d = retry_q;
      lost_d  = lost_q;
    end

    timer_d = (soft_req || (state_d != state_q)) ? '0 : timer_q + TMR_W'(1);

    // Outputs decode the next state so they change on the same edge as state_q.
    pll_reset_d   = (state_d == ST_PLL_RST);
    sys_reset_n_d = (state_d == ST_RUN);
    locked_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_PLL_RST;
      timer_q       <= '0;
      retry_q       <= '0;
      lost_q        <= '0;
      pll_reset_q   <= 1'b1;
      sys_reset_n_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      lost_q        <= lost_d;
      pll_reset_q   <= pll_reset_d;
      sys_reset_n_q <= sys_reset_n_d;
      locked_q      <= locked_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign sys_reset_n = sys_reset_n_q;
  assign locked      = locked_q;
  assign state       = state_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule
